// File: rtl/mult_share_pkg.sv
// -----------------------------------------------------------------------------
// mult_share_pkg
// Shared definitions for the multiplier-sharing controller: the controller FSM
// state encoding and the operand/product widths of the shared multiplier.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_share_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/WallaceTreeMulti.sv
// -----------------------------------------------------------------------------
// WallaceTreeMulti
// Combinational 32x32 signed multiplier producing the full 64-bit
// two's-complement product. Synthesis maps the multiply onto a
// partial-product reduction tree.
// Ports:
//   a_i       in  32  signed multiplicand
//   b_i       in  32  signed multiplier
//   product_o out 64  signed product a_i*b_i
// -----------------------------------------------------------------------------
module WallaceTreeMulti (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic signed [63:0] product_o
);

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // unsigned product equal to the exact signed product.
  assign product_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

endmodule

// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
// NUM_REQ-way arbiter for the shared multiplier.
// Macro MULT_SHARE_RR_EN: defined -> round-robin (pointer moves to one past
// the last granted index); undefined -> fixed priority, lowest index wins.
// Ports:
//   clk         in  1        clock
//   rst         in  1        synchronous active-high reset (clears pointer)
//   req_i       in  NUM_REQ  request vector
//   en_i        in  1        grants allowed this cycle
//   advance_i   in  1        a grant was taken; move the RR pointer
//   grant_o     out NUM_REQ  one-hot grant
//   grant_idx_o out ID_W     encoded grant index (0 when no grant)
// -----------------------------------------------------------------------------
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic found;

`ifdef MULT_SHARE_RR_EN

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] candIdx;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ; the
  // extra bit in cand keeps the sum from overflowing before the wrap.
  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    candIdx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      candIdx = cand[ID_W-1:0];
      if (!found && en_i && req_i[candIdx]) begin
        found       = 1'b1;
        grant_idx_o = candIdx;
      end
    end
    grant_o = found ? (NUM_REQ'(1) << grant_idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == ID_W'(NUM_REQ-1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

`else

  // No pointer state in fixed-priority mode.
  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance_i};

  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && en_i && req_i[i]) begin
        found       = 1'b1;
        grant_idx_o = ID_W'(i);
      end
    end
    grant_o = found ? (NUM_REQ'(1) << grant_idx_o) : '0;
  end

`endif

endmodule

// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
// Shares one WallaceTreeMulti among NUM_REQ requesters. The winning operands
// are registered into the multiplier, the product is captured one cycle later
// and returned on a tagged response port with backpressure.
// Macro MULT_SHARE_RR_EN selects round-robin (defined) or fixed-priority
// (undefined) arbitration inside mult_share_arb.
// Ports:
//   clk          in  1           clock
//   rst          in  1           synchronous active-high reset
//   req_valid    in  NUM_REQ     operand-valid per requester
//   req_ready    out NUM_REQ     one-hot grant
//   req_a/req_b  in  NUM_REQ*32  packed signed operands, requester i at [32i+:32]
//   resp_valid   out 1           product available
//   resp_ready   in  1           consumer accepts product
//   resp_id      out ID_W        owner of the product
//   resp_result  out 64          signed product
// -----------------------------------------------------------------------------
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [PROD_W-1:0]       resp_result
);

  ms_state_e              state_q, state_d;
  logic signed [OP_W-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [ID_W-1:0]        id_q, respId_q;
  logic [PROD_W-1:0]      result_q;
  logic signed [PROD_W-1:0] product;
  logic                   arbEn, anyGrant;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grantIdx;

  // Grants only when nothing is in flight, or when the pending response
  // leaves this very cycle; reset suppresses grants.
  assign arbEn = !rst && ((state_q == MS_IDLE) ||
                          ((state_q == MS_DONE) && resp_ready));

  mult_share_arb #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_valid),
    .en_i       (arbEn),
    .advance_i  (anyGrant),
    .grant_o    (grant),
    .grant_idx_o(grantIdx)
  );

  assign anyGrant  = |grant;
  assign req_ready = grant;

  always_comb begin
    opA_d = opA_q;
    opB_d = opB_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        opA_d = req_a[i*OP_W +: OP_W];
        opB_d = req_b[i*OP_W +: OP_W];
      end
    end
  end

  WallaceTreeMulti u_mult (
    .a_i      (opA_q),
    .b_i      (opB_q),
    .product_o(product)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE: if (anyGrant) state_d = MS_CALC;
      MS_CALC: state_d = MS_DONE;
      MS_DONE: if (resp_ready) state_d = anyGrant ? MS_CALC : MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // The response id is held separately from the operand id so a grant in
  // DONE can load the next owner without disturbing the visible response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      id_q     <= '0;
      respId_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      if (anyGrant) id_q <= grantIdx;
      if (state_q == MS_CALC) begin
        result_q <= product;
        respId_q <= id_q;
      end
    end
  end

  assign resp_valid  = (state_q == MS_DONE);
  assign resp_id     = respId_q;
  assign resp_result = result_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_share_ctrl
// Directed self-checking bench for mult_share_ctrl (NUM_REQ=4). Contention
// expectations follow MULT_SHARE_RR_EN.
// -----------------------------------------------------------------------------
module tb_mult_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [63:0]          resp_result;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_share_ctrl #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result)
  );

  // Outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands on one requester and raise its valid.
  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid[idx]      = 1'b1;
    #1;
  endtask

  task automatic doReset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Full transaction on one requester with resp_ready high; bounded waits.
  task automatic runOp(input int idx, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output logic [ID_W-1:0] id,
                       output bit timedOut);
    int n;
    timedOut   = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(idx, a, b);
    n = 0;
    while (!req_ready[idx] && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready[idx]) timedOut = 1'b1;
    tick();
    req_valid[idx] = 1'b0;
    #1;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!resp_valid) timedOut = 1'b1;
    res = resp_result;
    id  = resp_id;
    tick();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b1;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
    end
    checks++;
    if (resp_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id);
    end
    checks++;
    if (resp_result !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_resp_result: got %h expected 0", resp_result);
    end
    req_valid = '0;
    rst       = 1'b0;
    #1;
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    applyStimulus(0, 32'd1, -32'sd90);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_grant: got %b expected 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_calc_valid: got %b expected 0", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_latency: resp_valid got %b expected 1", resp_valid);
    end
    checks++;
    if (resp_result !== -64'sd90) begin
      errors++;
      $display("[TB] FAIL single_result: got %0d expected -90", $signed(resp_result));
    end
    checks++;
    if (resp_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_id: got %0d expected 0", resp_id);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drain: resp_valid got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_sign();
    logic [31:0]     aTab [3];
    logic [31:0]     bTab [3];
    logic [63:0]     expTab [3];
    logic [63:0]     res;
    logic [ID_W-1:0] id;
    bit              to;
    aTab[0] = -32'sd5; bTab[0] = -32'sd7; expTab[0] = 64'sd35;
    aTab[1] = -32'sd5; bTab[1] =  32'sd7; expTab[1] = -64'sd35;
    aTab[2] =  32'sd0; bTab[2] = -32'sd24; expTab[2] = 64'sd0;
    for (int i = 0; i < 3; i++) begin
      runOp(1, aTab[i], bTab[i], res, id, to);
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL sign_timeout[%0d]: handshake did not complete", i);
      end
      checks++;
      if (res !== expTab[i]) begin
        errors++;
        $display("[TB] FAIL sign_result[%0d]: got %0d expected %0d", i, $signed(res), $signed(expTab[i]));
      end
      checks++;
      if (id !== 2'd1) begin
        errors++;
        $display("[TB] FAIL sign_id[%0d]: got %0d expected 1", i, id);
      end
    end
  endtask

  task automatic test_contention();
    logic [ID_W-1:0] gotId  [4];
    logic [63:0]     gotRes [4];
    logic [ID_W-1:0] expId;
    logic [63:0]     expRes;
    int count;
    int cyc;
    doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1);
      req_b[i*32 +: 32] = 32'd10;
      gotId[i]  = '0;
      gotRes[i] = '0;
    end
    req_valid = '1;
    #1;
    count = 0;
    cyc   = 0;
    while (count < 4 && cyc < 40) begin
      if (resp_valid) begin
        gotId[count]  = resp_id;
        gotRes[count] = resp_result;
        count++;
        if (count == 4) begin
          req_valid = '0;
          #1;
        end
      end
      tick();
      cyc++;
    end
    req_valid = '0;
    checks++;
    if (count != 4) begin
      errors++;
      $display("[TB] FAIL contention_count: got %0d responses expected 4", count);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_SHARE_RR_EN
      expId  = ID_W'(i);
      expRes = 64'(10 * (i + 1));
`else
      expId  = '0;
      expRes = 64'd10;
`endif
      checks++;
      if (gotId[i] !== expId || gotRes[i] !== expRes) begin
        errors++;
        $display("[TB] FAIL contention[%0d]: got id %0d result %0d expected id %0d result %0d",
                 i, gotId[i], gotRes[i], expId, expRes);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    applyStimulus(0, 32'd234, 32'd345);
    tick();
    req_valid[0] = 1'b0;
    #1;
    tick();
    applyStimulus(2, 32'd13, 32'd10);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 64'd80730 || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: got valid %b result %0d id %0d ready %b expected 1 80730 0 0000",
                 i, resp_valid, resp_result, resp_id, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL backpressure_regrant: got %b expected 0100", req_ready);
    end
    checks++;
    if (resp_result !== 64'd80730) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got %0d expected 80730", resp_result);
    end
    tick();
    req_valid[2] = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_calc: resp_valid got %b expected 0", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 64'd130 || resp_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL backpressure_next: got valid %b result %0d id %0d expected 1 130 2",
               resp_valid, resp_result, resp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    resp_ready = 1'b1;
    applyStimulus(1, 32'd6, 32'd7);
    tick();
    req_valid[1] = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_result !== 64'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got valid %b id %0d result %0d ready %b expected 0 0 0 0000",
               resp_valid, resp_id, resp_result, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_dropped[%0d]: resp_valid got %b expected 0", i, resp_valid);
      end
    end
    applyStimulus(2, 32'd5, 32'd5);
    applyStimulus(0, 32'd3, 32'd4);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midreset_first_grant: got %b expected 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 64'd12 || resp_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midreset_result: got valid %b result %0d id %0d expected 1 12 0",
               resp_valid, resp_result, resp_id);
    end
    tick();
    req_valid[2] = 1'b0;
    #1;
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 64'd25 || resp_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL midreset_second: got valid %b result %0d id %0d expected 1 25 2",
               resp_valid, resp_result, resp_id);
    end
    tick();
  endtask

  task automatic test_wide();
    logic [63:0]     res;
    logic [ID_W-1:0] id;
    bit              to;
    runOp(0, 32'h7FFF_FFFF, 32'h8000_0000, res, id, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL wide_timeout: handshake did not complete");
    end
    checks++;
    if (res !== 64'hC000_0000_8000_0000) begin
      errors++;
      $display("[TB] FAIL wide_result: got %h expected c000000080000000", res);
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_sign();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
